// File: rtl/verificador_senha.sv
// rtl/verificador_senha.sv - keypad combination lock fed by debounced key pulses
// Compares a CODE_LEN digit entry against SENHA and drives timed open/error/lockout holds.
module verificador_senha #(
  parameter int                    CODE_LEN       = 4,
  parameter logic [2*CODE_LEN-1:0] SENHA          = 8'b00_01_10_11,
  parameter int                    MAX_TENTATIVAS = 3,
  parameter logic [31:0]           TEMPO_ABERTO   = 32'd150000000,
  parameter logic [31:0]           TEMPO_ERRO     = 32'd25000000,
  parameter logic [31:0]           TEMPO_BLOQUEIO = 32'd500000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] botao_pulso,
  output logic       aberto,
  output logic       erro,
  output logic       bloqueado,
  output logic [3:0] digitos,
  output logic [1:0] tentativas
);

  typedef enum logic [2:0] {
    ENTRADA,
    VERIFICA,
    ABERTO,
    ERRO,
    BLOQUEADO
  } estado_t;

  localparam logic [3:0] CODE_LEN_V = 4'(CODE_LEN);
  localparam logic [1:0] MAX_V      = 2'(MAX_TENTATIVAS);

  estado_t     estado;
  logic        mismatch;
  logic [31:0] timer;

  logic        valido;
  logic [1:0]  digito;
  logic [1:0]  esperado;
  logic [3:0]  digitos_prox;

  always_comb begin
    // a press counts only when exactly one key pulsed this cycle
    valido = (botao_pulso != 4'd0) && ((botao_pulso & (botao_pulso - 4'd1)) == 4'd0);
    digito = 2'd0;
    case (botao_pulso)
      4'b0010: digito = 2'd1;
      4'b0100: digito = 2'd2;
      4'b1000: digito = 2'd3;
      default: digito = 2'd0;
    endcase
    esperado = 2'd0;
    for (int i = 0; i < CODE_LEN; i++) begin
      if (digitos == 4'(i)) esperado = SENHA[2*(CODE_LEN-1-i) +: 2];
    end
    digitos_prox = digitos + 4'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado     <= ENTRADA;
      mismatch   <= 1'b0;
      timer      <= 32'd0;
      digitos    <= 4'd0;
      tentativas <= 2'd0;
      aberto     <= 1'b0;
      erro       <= 1'b0;
      bloqueado  <= 1'b0;
    end else begin
      case (estado)
        ENTRADA: begin
          timer <= 32'd0;
          if (valido) begin
            digitos <= digitos_prox;
            if (digito != esperado) mismatch <= 1'b1;
            if (digitos_prox == CODE_LEN_V) estado <= VERIFICA;
          end
        end

        VERIFICA: begin
          digitos  <= 4'd0;
          mismatch <= 1'b0;
          timer    <= 32'd0;
          if (!mismatch) begin
            estado     <= ABERTO;
            aberto     <= 1'b1;
            tentativas <= 2'd0;
          end else if (tentativas + 2'd1 == MAX_V) begin
            estado     <= BLOQUEADO;
            bloqueado  <= 1'b1;
            tentativas <= MAX_V;
          end else begin
            estado     <= ERRO;
            erro       <= 1'b1;
            tentativas <= tentativas + 2'd1;
          end
        end

        ABERTO: begin
          if (timer == TEMPO_ABERTO - 32'd1) begin
            estado <= ENTRADA;
            aberto <= 1'b0;
            timer  <= 32'd0;
          end else begin
            timer <= timer + 32'd1;
          end
        end

        ERRO: begin
          if (timer == TEMPO_ERRO - 32'd1) begin
            estado <= ENTRADA;
            erro   <= 1'b0;
            timer  <= 32'd0;
          end else begin
            timer <= timer + 32'd1;
          end
        end

        BLOQUEADO: begin
          // the lockout itself is the penalty, so the failure count starts over
          if (timer == TEMPO_BLOQUEIO - 32'd1) begin
            estado     <= ENTRADA;
            bloqueado  <= 1'b0;
            tentativas <= 2'd0;
            timer      <= 32'd0;
          end else begin
            timer <= timer + 32'd1;
          end
        end

        default: begin
          estado <= ENTRADA;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_verificador_senha.sv
// tb/tb_verificador_senha.sv - randomized attempt-level bench for verificador_senha
module tb_verificador_senha;

  localparam int T_AB  = 5;
  localparam int T_ER  = 4;
  localparam int T_BL  = 6;
  localparam int MAX_T = 3;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] botao_pulso;
  logic       aberto, erro, bloqueado;
  logic [3:0] digitos;
  logic [1:0] tentativas;

  int n_checks = 0;
  int n_pass   = 0;
  int fails_model = 0;
  int codigo[4] = '{0, 1, 2, 3};
  int att[4];

  verificador_senha #(
    .CODE_LEN      (4),
    .SENHA         (8'b00_01_10_11),
    .MAX_TENTATIVAS(MAX_T),
    .TEMPO_ABERTO  (32'd5),
    .TEMPO_ERRO    (32'd4),
    .TEMPO_BLOQUEIO(32'd6)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .botao_pulso(botao_pulso),
    .aberto     (aberto),
    .erro       (erro),
    .bloqueado  (bloqueado),
    .digitos    (digitos),
    .tentativas (tentativas)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [8:0] obs();
    return {aberto, erro, bloqueado, digitos, tentativas};
  endfunction

  function automatic logic [3:0] multi_bits();
    logic [3:0] v;
    v = 4'($urandom);
    while ($countones(v) < 2) v = 4'($urandom);
    return v;
  endfunction

  // Drives att[] as one attempt with ignored noise between presses, then
  // checks the outcome hold against the attempt-level model.
  task automatic run_attempt(input bit noise_hold, input string nome);
    int q[$];
    logic [8:0] exp_v;
    logic [2:0] ind;
    int tent, hold, newf;
    bit match;
    q = {};
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 2)) begin
        botao_pulso = ($urandom_range(0, 1) == 1) ? multi_bits() : 4'd0;
        tick();
        botao_pulso = 4'd0;
        exp_v = {3'b000, 4'(q.size()), 2'(fails_model)};
        n_checks++;
        if (obs() !== exp_v) $display("FAIL %s gap%0d: got %b expected %b", nome, i, obs(), exp_v);
        else n_pass++;
      end
      botao_pulso = 4'(1 << att[i]);
      tick();
      botao_pulso = 4'd0;
      q.push_back(att[i]);
      exp_v = {3'b000, 4'(q.size()), 2'(fails_model)};
      n_checks++;
      if (obs() !== exp_v) $display("FAIL %s press%0d: got %b expected %b", nome, i, obs(), exp_v);
      else n_pass++;
    end
    match = 1'b1;
    foreach (q[i]) if (q[i] != codigo[i]) match = 1'b0;
    if (match) begin
      ind = 3'b100; tent = 0; hold = T_AB; newf = 0;
    end else if (fails_model + 1 == MAX_T) begin
      ind = 3'b001; tent = MAX_T; hold = T_BL; newf = 0;
    end else begin
      ind = 3'b010; tent = fails_model + 1; hold = T_ER; newf = fails_model + 1;
    end
    tick();
    for (int k = 0; k < hold; k++) begin
      exp_v = {ind, 4'd0, 2'(tent)};
      n_checks++;
      if (obs() !== exp_v) $display("FAIL %s hold%0d: got %b expected %b", nome, k, obs(), exp_v);
      else n_pass++;
      botao_pulso = noise_hold ? 4'($urandom) : 4'd0;
      tick();
      botao_pulso = 4'd0;
    end
    fails_model = newf;
    exp_v = {3'b000, 4'd0, 2'(fails_model)};
    n_checks++;
    if (obs() !== exp_v) $display("FAIL %s after: got %b expected %b", nome, obs(), exp_v);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    botao_pulso = 4'd0;
    tick();
    tick();
    reset = 1'b0;
    fails_model = 0;
    n_checks++;
    if (obs() !== 9'd0) $display("FAIL reset: got %b expected %b", obs(), 9'd0);
    else n_pass++;
  endtask

  task automatic test_correct();
    att = '{0, 1, 2, 3};
    run_attempt(1'b0, "correct");
  endtask

  task automatic test_wrong();
    att = '{0, 1, 2, 2};
    run_attempt(1'b0, "wrong");
    n_checks++;
    if (tentativas !== 2'd1) $display("FAIL wrong_tent: got %0d expected 1", tentativas);
    else n_pass++;
  endtask

  task automatic test_lockout();
    att = '{3, 3, 1, 0};
    while (fails_model + 1 < MAX_T) run_attempt(1'b0, "lock_pre");
    run_attempt(1'b1, "lockout");
    att = '{0, 1, 2, 3};
    run_attempt(1'b0, "after_lock");
  endtask

  task automatic test_counter_reset();
    att = '{1, 1, 2, 3};
    run_attempt(1'b0, "cnt_w1");
    run_attempt(1'b0, "cnt_w2");
    att = '{0, 1, 2, 3};
    run_attempt(1'b1, "cnt_ok");
    att = '{0, 1, 2, 0};
    run_attempt(1'b0, "cnt_w3");
    n_checks++;
    if (tentativas !== 2'd1) $display("FAIL cnt_tent: got %0d expected 1", tentativas);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    botao_pulso = 4'b0001;
    tick();
    botao_pulso = 4'b0011;
    tick();
    botao_pulso = 4'b1111;
    tick();
    botao_pulso = 4'd0;
    n_checks++;
    if (digitos !== 4'd1 || erro !== 1'b0) $display("FAIL simult: got digitos %0d erro %b expected 1 0", digitos, erro);
    else n_pass++;
    att = '{1, 2, 3, 0};
    reset = 1'b1;
    tick();
    reset = 1'b0;
    fails_model = 0;
  endtask

  task automatic test_reset_mid();
    att = '{2, 2, 2, 2};
    run_attempt(1'b0, "rst_pre");
    botao_pulso = 4'b1000;
    tick();
    botao_pulso = 4'b0100;
    tick();
    botao_pulso = 4'd0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    fails_model = 0;
    n_checks++;
    if (obs() !== 9'd0) $display("FAIL rst_entry: got %b expected %b", obs(), 9'd0);
    else n_pass++;
    att = '{0, 1, 2, 3};
    run_attempt(1'b0, "rst_reopen");
    for (int i = 0; i < 4; i++) begin
      botao_pulso = 4'(1 << i);
      tick();
    end
    botao_pulso = 4'd0;
    tick();
    tick();
    n_checks++;
    if (aberto !== 1'b1) $display("FAIL rst_ab_pre: got %b expected 1", aberto);
    else n_pass++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if (obs() !== 9'd0) $display("FAIL rst_aberto: got %b expected %b", obs(), 9'd0);
    else n_pass++;
    run_attempt(1'b0, "rst_after_ab");
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < 4; i++)
        att[i] = ($urandom_range(0, 9) < 7) ? codigo[i] : int'($urandom_range(0, 3));
      run_attempt(1'($urandom_range(0, 1)), "random");
    end
  endtask

  initial begin
    reset = 1'b0;
    botao_pulso = 4'd0;
    test_reset();
    test_correct();
    test_wrong();
    test_lockout();
    test_counter_reset();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
